// File: rtl/rob_wb_arbiter.sv
// Writeback arbiter: three one-entry holding buffers drained into the ROB result-write port.
// Optional macro WB_FIXED_PRIO_EN selects fixed priority BR > LSB > ALU instead of round-robin.
module rob_wb_arbiter #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              alu_valid,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_value,
    output logic              alu_accept,
    input  logic              lsb_valid,
    input  logic [TAG_W-1:0]  lsb_tag,
    input  logic [DATA_W-1:0] lsb_value,
    output logic              lsb_accept,
    input  logic              br_valid,
    input  logic [TAG_W-1:0]  br_tag,
    input  logic [DATA_W-1:0] br_value,
    input  logic [DATA_W-1:0] br_topc,
    output logic              br_accept,
    output logic              wb_valid,
    output logic [TAG_W-1:0]  wb_tag,
    output logic [DATA_W-1:0] wb_value,
    output logic [DATA_W-1:0] wb_topc,
    output logic              wb_topc_valid,
    output logic [1:0]        wb_src
);

    localparam int NSRC = 3;

    logic [NSRC-1:0]   in_v;
    logic [TAG_W-1:0]  in_tag   [NSRC];
    logic [DATA_W-1:0] in_value [NSRC];

    assign in_v        = {br_valid, lsb_valid, alu_valid};
    assign in_tag[0]   = alu_tag;
    assign in_tag[1]   = lsb_tag;
    assign in_tag[2]   = br_tag;
    assign in_value[0] = alu_value;
    assign in_value[1] = lsb_value;
    assign in_value[2] = br_value;

    logic [NSRC-1:0]   buf_v_q, buf_v_d;
    logic [TAG_W-1:0]  buf_tag_q   [NSRC];
    logic [TAG_W-1:0]  buf_tag_d   [NSRC];
    logic [DATA_W-1:0] buf_value_q [NSRC];
    logic [DATA_W-1:0] buf_value_d [NSRC];
    logic [DATA_W-1:0] buf_topc_q, buf_topc_d;

    logic              wb_valid_q, wb_valid_d;
    logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
    logic [DATA_W-1:0] wb_value_q, wb_value_d;
    logic [DATA_W-1:0] wb_topc_q, wb_topc_d;
    logic              wb_topc_valid_q, wb_topc_valid_d;
    logic [1:0]        wb_src_q, wb_src_d;

    logic [NSRC-1:0] grant;
    logic [NSRC-1:0] accept;
    logic [1:0]      gidx;
    logic            go;

    assign go = rdy & ~clear;

`ifdef WB_FIXED_PRIO_EN
    always_comb begin
        grant = '0;
        gidx  = 2'd0;
        if (go) begin
            if (buf_v_q[2]) begin
                grant = 3'b100;
                gidx  = 2'd2;
            end else if (buf_v_q[1]) begin
                grant = 3'b010;
                gidx  = 2'd1;
            end else if (buf_v_q[0]) begin
                grant = 3'b001;
                gidx  = 2'd0;
            end
        end
    end
`else
    logic [1:0] rr_q, rr_d;
    logic [1:0] idx;
    logic       found;

    // Walk the three sources starting at rr, wrapping 2 -> 0.
    always_comb begin
        grant = '0;
        gidx  = 2'd0;
        found = 1'b0;
        idx   = rr_q;
        for (int i = 0; i < NSRC; i++) begin
            if (go && !found && buf_v_q[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
        if (found) begin
            grant = 3'b001 << gidx;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (rdy && clear) begin
            rr_d = 2'd0;
        end else if (|grant) begin
            rr_d = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= 2'd0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // Gated by rst so accepts read 0 while reset is held.
    assign accept     = {NSRC{rst & go}} & (~buf_v_q | grant);
    assign alu_accept = accept[0];
    assign lsb_accept = accept[1];
    assign br_accept  = accept[2];

    always_comb begin
        buf_v_d     = buf_v_q;
        buf_tag_d   = buf_tag_q;
        buf_value_d = buf_value_q;
        buf_topc_d  = buf_topc_q;
        if (rdy && clear) begin
            buf_v_d = '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (in_v[i] && accept[i]) begin
                    buf_v_d[i]     = 1'b1;
                    buf_tag_d[i]   = in_tag[i];
                    buf_value_d[i] = in_value[i];
                end else if (grant[i]) begin
                    buf_v_d[i] = 1'b0;
                end
            end
            if (in_v[2] && accept[2]) begin
                buf_topc_d = br_topc;
            end
        end
    end

    always_comb begin
        wb_valid_d      = wb_valid_q;
        wb_tag_d        = wb_tag_q;
        wb_value_d      = wb_value_q;
        wb_topc_d       = wb_topc_q;
        wb_topc_valid_d = wb_topc_valid_q;
        wb_src_d        = wb_src_q;
        if (rdy) begin
            if (clear) begin
                wb_valid_d      = 1'b0;
                wb_topc_valid_d = 1'b0;
            end else if (|grant) begin
                wb_valid_d      = 1'b1;
                wb_tag_d        = buf_tag_q[gidx];
                wb_value_d      = buf_value_q[gidx];
                wb_src_d        = gidx;
                wb_topc_valid_d = grant[2];
                wb_topc_d       = grant[2] ? buf_topc_q : '0;
            end else begin
                wb_valid_d      = 1'b0;
                wb_topc_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_v_q    <= '0;
            buf_topc_q <= '0;
            for (int i = 0; i < NSRC; i++) begin
                buf_tag_q[i]   <= '0;
                buf_value_q[i] <= '0;
            end
            wb_valid_q      <= 1'b0;
            wb_tag_q        <= '0;
            wb_value_q      <= '0;
            wb_topc_q       <= '0;
            wb_topc_valid_q <= 1'b0;
            wb_src_q        <= 2'd0;
        end else begin
            buf_v_q     <= buf_v_d;
            buf_tag_q   <= buf_tag_d;
            buf_value_q <= buf_value_d;
            buf_topc_q  <= buf_topc_d;
            wb_valid_q      <= wb_valid_d;
            wb_tag_q        <= wb_tag_d;
            wb_value_q      <= wb_value_d;
            wb_topc_q       <= wb_topc_d;
            wb_topc_valid_q <= wb_topc_valid_d;
            wb_src_q        <= wb_src_d;
        end
    end

    assign wb_valid      = wb_valid_q;
    assign wb_tag        = wb_tag_q;
    assign wb_value      = wb_value_q;
    assign wb_topc       = wb_topc_q;
    assign wb_topc_valid = wb_topc_valid_q;
    assign wb_src        = wb_src_q;

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Scoreboard bench for rob_wb_arbiter; expected writebacks are queued in spec order.
module tb_rob_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, clear;
    logic        alu_valid, lsb_valid, br_valid;
    logic [3:0]  alu_tag, lsb_tag, br_tag;
    logic [31:0] alu_value, lsb_value, br_value, br_topc;
    logic        alu_accept, lsb_accept, br_accept;
    logic        wb_valid, wb_topc_valid;
    logic [3:0]  wb_tag;
    logic [31:0] wb_value, wb_topc;
    logic [1:0]  wb_src;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] val;
        logic [1:0]  src;
        logic        tv;
        logic [31:0] topc;
    } exp_t;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] val;
        logic [31:0] topc;
    } item_t;

    exp_t  sb[$];
    item_t q_alu[$];
    item_t q_lsb[$];
    item_t q_br[$];
    logic [2:0] acc_hist[16];

    always #5 clk = ~clk;

    rob_wb_arbiter #(.TAG_W(4), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .alu_valid(alu_valid), .alu_tag(alu_tag),
        .alu_value(alu_value), .alu_accept(alu_accept),
        .lsb_valid(lsb_valid), .lsb_tag(lsb_tag),
        .lsb_value(lsb_value), .lsb_accept(lsb_accept),
        .br_valid(br_valid), .br_tag(br_tag), .br_value(br_value),
        .br_topc(br_topc), .br_accept(br_accept),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .wb_topc(wb_topc), .wb_topc_valid(wb_topc_valid),
        .wb_src(wb_src)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic item_t mk(input logic [3:0] t);
        item_t it;
        it.tag  = t;
        it.val  = 32'hA000 + 32'(t);
        it.topc = 32'h8000_0000 + 32'(t) * 4;
        return it;
    endfunction

    function automatic exp_t ex(input item_t it, input logic [1:0] s);
        exp_t e;
        e.tag  = it.tag;
        e.val  = it.val;
        e.src  = s;
        e.tv   = (s == 2'd2);
        e.topc = (s == 2'd2) ? it.topc : 32'h0;
        return e;
    endfunction

    // Each write the output register takes (edge with rdy and rst high) pops one entry.
    always @(posedge clk) begin
        logic ld;
        exp_t e;
        ld = rdy && rst;
        #1;
        if (ld && wb_valid) begin
            chk("sb_has_entry", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wb_tag", 64'(wb_tag), 64'(e.tag));
                chk("wb_value", 64'(wb_value), 64'(e.val));
                chk("wb_src", 64'(wb_src), 64'(e.src));
                chk("wb_topc_valid", 64'(wb_topc_valid), 64'(e.tv));
                chk("wb_topc", 64'(wb_topc), 64'(e.topc));
            end
        end
    end

    // Producers offer their queue heads and drop each item once accepted.
    task automatic run_prod(input int ncyc);
        logic [2:0] acc;
        for (int c = 0; c < ncyc; c++) begin
            alu_valid = q_alu.size() > 0;
            lsb_valid = q_lsb.size() > 0;
            br_valid  = q_br.size() > 0;
            if (alu_valid) begin
                alu_tag = q_alu[0].tag;
                alu_value = q_alu[0].val;
            end
            if (lsb_valid) begin
                lsb_tag = q_lsb[0].tag;
                lsb_value = q_lsb[0].val;
            end
            if (br_valid) begin
                br_tag = q_br[0].tag;
                br_value = q_br[0].val;
                br_topc = q_br[0].topc;
            end
            #1;
            acc = {br_accept, lsb_accept, alu_accept};
            if (c < 16) acc_hist[c] = acc;
            @(posedge clk);
            if (alu_valid && acc[0]) void'(q_alu.pop_front());
            if (lsb_valid && acc[1]) void'(q_lsb.pop_front());
            if (br_valid && acc[2]) void'(q_br.pop_front());
            #1;
        end
        alu_valid = 1'b0;
        lsb_valid = 1'b0;
        br_valid  = 1'b0;
    endtask

    task automatic offer_all(input logic [3:0] ta, input logic [3:0] tl,
                             input logic [3:0] tb);
        q_alu.push_back(mk(ta));
        q_lsb.push_back(mk(tl));
        q_br.push_back(mk(tb));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; rdy = 1'b1; clear = 1'b0;
        alu_valid = 1'b1; lsb_valid = 1'b0; br_valid = 1'b0;
        alu_tag = 4'd0; lsb_tag = 4'd0; br_tag = 4'd0;
        alu_value = '0; lsb_value = '0; br_value = '0; br_topc = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_wb_tag", 64'(wb_tag), 64'd0);
        chk("rst_wb_value", 64'(wb_value), 64'd0);
        chk("rst_wb_topc", 64'(wb_topc), 64'd0);
        chk("rst_wb_topc_valid", 64'(wb_topc_valid), 64'd0);
        chk("rst_wb_src", 64'(wb_src), 64'd0);
        chk("rst_accepts", 64'({br_accept, lsb_accept, alu_accept}), 64'd0);
        alu_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();

        // single ALU result
        alu_valid = 1'b1; alu_tag = 4'd5; alu_value = 32'h1234;
        #1;
        chk("single_accept", 64'(alu_accept), 64'd1);
        sb.push_back('{tag: 4'd5, val: 32'h1234, src: 2'd0, tv: 1'b0, topc: 32'h0});
        tick();
        alu_valid = 1'b0;
        chk("single_lat_wait", 64'(wb_valid), 64'd0);
        tick();
        chk("single_lat_valid", 64'(wb_valid), 64'd1);
        tick();
        chk("single_idle", 64'(wb_valid), 64'd0);

        // branch writeback
        br_valid = 1'b1; br_tag = 4'd7; br_value = 32'd1; br_topc = 32'h80;
        #1;
        chk("br_accept", 64'(br_accept), 64'd1);
        sb.push_back('{tag: 4'd7, val: 32'd1, src: 2'd2, tv: 1'b1, topc: 32'h80});
        tick();
        br_valid = 1'b0;
        repeat (3) tick();

        // flush with all three buffers full
        offer_all(4'd8, 4'd9, 4'd10);
        run_prod(1);
        clear = 1'b1;
        #1;
        chk("clear_accepts", 64'({br_accept, lsb_accept, alu_accept}), 64'd0);
        tick();
        clear = 1'b0;
        chk("clear_wb_valid", 64'(wb_valid), 64'd0);
        chk("clear_topc_valid", 64'(wb_topc_valid), 64'd0);
        repeat (3) begin
            tick();
            chk("clear_no_stale", 64'(wb_valid), 64'd0);
        end

        // contention from rr=0
        offer_all(4'd1, 4'd2, 4'd3);
`ifdef WB_FIXED_PRIO_EN
        sb.push_back(ex(mk(4'd3), 2'd2));
        sb.push_back(ex(mk(4'd2), 2'd1));
        sb.push_back(ex(mk(4'd1), 2'd0));
`else
        sb.push_back(ex(mk(4'd1), 2'd0));
        sb.push_back(ex(mk(4'd2), 2'd1));
        sb.push_back(ex(mk(4'd3), 2'd2));
`endif
        run_prod(1);
        chk("cont_all_acc", 64'(acc_hist[0]), 64'd7);
        repeat (3) begin
            tick();
            chk("cont_back2back", 64'(wb_valid), 64'd1);
        end
        repeat (2) tick();

        // all full, all offering: only the granted source refills
        offer_all(4'd1, 4'd2, 4'd3);
        offer_all(4'd9, 4'd10, 4'd11);
`ifdef WB_FIXED_PRIO_EN
        sb.push_back(ex(mk(4'd3), 2'd2));
        sb.push_back(ex(mk(4'd11), 2'd2));
        sb.push_back(ex(mk(4'd2), 2'd1));
        sb.push_back(ex(mk(4'd10), 2'd1));
        sb.push_back(ex(mk(4'd1), 2'd0));
        sb.push_back(ex(mk(4'd9), 2'd0));
`else
        sb.push_back(ex(mk(4'd1), 2'd0));
        sb.push_back(ex(mk(4'd2), 2'd1));
        sb.push_back(ex(mk(4'd3), 2'd2));
        sb.push_back(ex(mk(4'd9), 2'd0));
        sb.push_back(ex(mk(4'd10), 2'd1));
        sb.push_back(ex(mk(4'd11), 2'd2));
`endif
        run_prod(8);
`ifdef WB_FIXED_PRIO_EN
        chk("full_refill_acc", 64'(acc_hist[1]), 64'd4);
`else
        chk("full_refill_acc", 64'(acc_hist[1]), 64'd1);
`endif
        repeat (6) tick();
        chk("full_drained", 64'(sb.size()), 64'd0);

        // stall with rdy low
        alu_valid = 1'b1; alu_tag = 4'd4; alu_value = 32'h44;
        #1;
        chk("stall_pre_acc", 64'(alu_accept), 64'd1);
        sb.push_back('{tag: 4'd4, val: 32'h44, src: 2'd0, tv: 1'b0, topc: 32'h0});
        tick();
        alu_valid = 1'b0;
        tick();
        rdy = 1'b0; alu_valid = 1'b1; alu_tag = 4'd6; alu_value = 32'h66;
        repeat (3) begin
            #1;
            chk("stall_acc", 64'(alu_accept), 64'd0);
            chk("stall_wb_valid", 64'(wb_valid), 64'd1);
            chk("stall_wb_tag", 64'(wb_tag), 64'd4);
            tick();
        end
        rdy = 1'b1;
        #1;
        chk("stall_resume_acc", 64'(alu_accept), 64'd1);
        sb.push_back('{tag: 4'd6, val: 32'h66, src: 2'd0, tv: 1'b0, topc: 32'h0});
        tick();
        alu_valid = 1'b0;
        repeat (3) tick();

        // async reset with buffers full
        clear = 1'b1;
        tick();
        clear = 1'b0;
        offer_all(4'd12, 4'd13, 4'd14);
`ifdef WB_FIXED_PRIO_EN
        sb.push_back(ex(mk(4'd14), 2'd2));
`else
        sb.push_back(ex(mk(4'd12), 2'd0));
`endif
        run_prod(1);
        tick();
        #2;
        rst = 1'b0;
        clear = 1'b1;
        #1;
        chk("arst_wb_valid", 64'(wb_valid), 64'd0);
        chk("arst_wb_tag", 64'(wb_tag), 64'd0);
        chk("arst_wb_value", 64'(wb_value), 64'd0);
        chk("arst_wb_topc", 64'(wb_topc), 64'd0);
        chk("arst_wb_topc_valid", 64'(wb_topc_valid), 64'd0);
        chk("arst_wb_src", 64'(wb_src), 64'd0);
        chk("arst_accepts", 64'({br_accept, lsb_accept, alu_accept}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        clear = 1'b0;
        repeat (4) begin
            tick();
            chk("arst_discarded", 64'(wb_valid), 64'd0);
        end

        chk("sb_empty_end", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rob_wb_arbiter.md
# rob_wb_arbiter

Writeback arbiter that shares the reorder buffer's single result-write port among three producers: the ALU reservation station, the load/store buffer and the branch unit. Each producer owns a one-entry holding buffer. A round-robin arbiter drains one buffered result per cycle into a registered write port. The ROB consumes that port as its result-write input, setting value/ready and, for branches, the resolved target.

## Interface
Parameters:
- TAG_W, 4: ROB index width (16 entries).
- DATA_W, 32: result and target-PC width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- rdy  input  1  global enable; low freezes all state.
- clear  input  1  pipeline flush; drops all buffered results.
- alu_valid  input  1  ALU result offered.
- alu_tag  input  TAG_W  ROB index of the ALU result.
- alu_value  input  DATA_W  ALU result.
- alu_accept  output  1  ALU result captured this cycle.
- lsb_valid  input  1  load/store completion offered.
- lsb_tag  input  TAG_W  ROB index of the load/store completion.
- lsb_value  input  DATA_W  load data (0 for stores).
- lsb_accept  output  1  load/store completion captured this cycle.
- br_valid  input  1  branch resolution offered.
- br_tag  input  TAG_W  ROB index of the branch.
- br_value  input  DATA_W  branch outcome or link value.
- br_topc  input  DATA_W  resolved branch target.
- br_accept  output  1  branch resolution captured this cycle.
- wb_valid  output  1  ROB write strobe.
- wb_tag  output  TAG_W  ROB entry to mark ready.
- wb_value  output  DATA_W  value written.
- wb_topc  output  DATA_W  target PC written.
- wb_topc_valid  output  1  target-PC write enable; set only for branch results.
- wb_src  output  2  source of the current write: 0 ALU, 1 LSB, 2 BR.

## Operation
- Per-source state: buf_v, buf_tag, buf_value, plus buf_topc for BR only.
- Accept (combinational): x_accept = rdy & ~clear & (~buf_v[x] | grant[x]).
- Capture: when x_valid & x_accept, the buffer loads on the next edge. A granted source can refill its buffer in the same cycle, so a producer sustains one result per cycle.
- Producers hold valid, tag and data stable until accepted.
- Grant: one occupied buffer per cycle, chosen round-robin. Search starts at pointer rr (2 bits, values 0..2) in order ALU→LSB→BR.
- After a grant, rr moves to the granted index + 1, wrapping from 2 to 0.
- With no buffer occupied, rr holds.
- Output register, loaded when rdy & ~clear:
  - With a grant: wb_valid=1; wb_tag, wb_value and wb_src come from the granted buffer. wb_topc_valid=1 and wb_topc=buf_topc only if BR is granted; otherwise both are 0.
  - Without a grant: wb_valid=0 and wb_topc_valid=0; the data fields hold their previous values.
- clear takes priority over every other action:
  - all buf_v cleared; rr set to 0; wb_valid and wb_topc_valid set to 0;
  - no capture occurs that cycle, since all accepts are 0.
- rdy low:
  - no capture, no grant, all accepts 0;
  - every register holds, including wb_valid. The ROB also ignores its write port while rdy is low, so a held strobe does not double-write.
- No duplicate-tag checking. Two buffers carrying the same tag are written in grant order, and the last write wins.

## Timing
- Reset (asynchronous, immediate): buf_v=0, rr=0, and every output 0, i.e. wb_valid, wb_tag, wb_value, wb_topc, wb_topc_valid, wb_src, all accepts.
- Reset is released synchronously to clk.
- Latency: result captured at edge N; it appears on wb_* after edge N+1 at the earliest.
- Throughput: one writeback per cycle. Worst-case wait for a buffered result is 2 cycles behind the other sources.
- Boundary conditions:
  - All three buffers full with all sources offering: each granted source refills the same cycle; the other two see accept=0.
  - Reset asserted mid-operation discards buffered results without emitting them.
  - clear and reset both active: reset dominates.

## Configuration
- WB_FIXED_PRIO_EN
  - Defined: fixed priority BR > LSB > ALU; rr is not implemented. Branch resolutions reach the ROB first so mispredicts retire sooner.
  - Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

## Test plan
- Single result: alu_valid=1, tag=5, value=0x1234 for one cycle. alu_accept=1 in that cycle; one cycle later wb_valid=1, wb_tag=5, wb_value=0x1234, wb_src=0, wb_topc_valid=0.
- Contention: all three sources offer in the same cycle with rr=0 (tags 1/2/3), and each source drops valid once its own accept is seen.
  - Round-robin build: wb_tag sequence 1, 2, 3 on consecutive cycles.
  - WB_FIXED_PRIO_EN build: wb_tag sequence 3, 2, 1.
- Branch writeback: br tag=7, value=1, topc=0x80. Expect wb_topc_valid=1, wb_topc=0x80, wb_src=2.
- Flush: fill all three buffers, then assert clear for 1 cycle. Next cycle wb_valid=0, all buffers empty, rr=0; no stale tags are written afterwards.
- Stall: rdy=0 for 3 cycles while alu_valid=1. alu_accept stays 0 and wb_* stays frozen; capture resumes on the first cycle with rdy=1.
- Async reset: pull rst low mid-cycle with buffers full. Outputs go to 0 before the next clk edge.
